// File: rtl/upper_imm_ou_pkg.sv
// Shared configuration for the RCA operation units: datapath width,
// immediate-unit operation modes and the supported pipeline depth range.
// Latency: n/a (declarations only). Backpressure: n/a.
package rca_config;

  // Datapath width shared by every operation unit
  localparam int XLEN = 32;

  // Deepest result pipeline an operation unit may be built with
  localparam int OU_MAX_PIPE_DEPTH = 4;

  // Low immediate field used by ADDI-style arithmetic
  localparam int OU_IIMM_W = 12;

  // Operation selected per accepted operand set
  typedef enum logic [1:0] {
    OU_LUI   = 2'd0,
    OU_AUIPC = 2'd1,
    OU_ADDI  = 2'd2,
    OU_RSVD  = 2'd3
  } ou_imm_mode_t;

  // Sign-extend the low 12-bit immediate to the datapath width
  function automatic logic [XLEN-1:0] sext_iimm(input logic [XLEN-1:0] raw);
    return {{(XLEN-OU_IIMM_W){raw[OU_IIMM_W-1]}}, raw[OU_IIMM_W-1:0]};
  endfunction

endpackage

// File: rtl/upper_imm_ou_pipe_stage.sv
// One result slot of the operation-unit pipeline: valid bit plus data word.
// Latency: 1 cycle from load to visible contents.
// Backpressure: none internally; the caller drives load/clr from its advance chain.
module ou_pipe_stage #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic         clr,
  input  logic [W-1:0] d,
  output logic         vld,
  output logic [W-1:0] dat
);

  // Load wins over clear so a slot that hands off and refills in one cycle stays full
  always_ff @(posedge clk) begin
    if (rst) begin
      vld <= 1'b0;
      dat <= '0;
    end else if (load) begin
      vld <= 1'b1;
      dat <= d;
    end else if (clr) begin
      vld <= 1'b0;
    end
  end

endmodule

// File: rtl/upper_imm_ou.sv
// Upper-immediate operation unit: LUI / AUIPC / ADDI result into a PIPE_DEPTH-deep register pipeline.
// Latency: PIPE_DEPTH cycles from operand accept to data_valid_out; 1 result per cycle sustained.
// Backpressure: stages advance only into free slots; when stage 0 cannot advance operands are not acked.
// Optional: `define RCA_OU_STALL_CNT_EN adds a saturating output-stall counter on stall_count.
module upper_imm_ou
  import rca_config::*;
#(
  parameter int PIPE_DEPTH = 2,
  parameter int IMM_W      = 20
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [1:0]      mode,
  input  logic [XLEN-1:0] data_in1,
  input  logic [XLEN-1:0] data_in2,
  input  logic            data_valid_in1,
  input  logic            data_valid_in2,
  output logic            data_in_ack1,
  output logic            data_in_ack2,
  output logic            uses_data_in1,
  output logic            uses_data_in2,
  output logic [XLEN-1:0] data_out,
  output logic            data_valid_out,
  input  logic            data_out_ack,
  output logic [2:0]      occupancy,
  output logic [31:0]     stall_count,
  output logic [XLEN-1:0] addr,
  output logic [XLEN-1:0] data,
  output logic [2:0]      fn3,
  output logic            load,
  output logic            store,
  output logic            new_request,
  input  logic            lsq_full,
  input  logic [XLEN-1:0] load_data,
  input  logic            load_complete
);

  ou_imm_mode_t          mode_e;
  logic                  need2;
  logic                  ready;
  logic                  accept;
  logic [XLEN-1:0]       upper;
  logic [XLEN-1:0]       result;

  logic [PIPE_DEPTH-1:0] stg_vld;
  logic [PIPE_DEPTH-1:0] stg_move;
  logic [PIPE_DEPTH:0]   stg_free;
  logic [XLEN-1:0]       stg_dat [PIPE_DEPTH];

  assign mode_e = ou_imm_mode_t'(mode);

  // LUI never reads operand 2, so it must not wait for it or consume it
  assign need2 = (mode_e != OU_LUI);
  assign ready = data_valid_in1 && (!need2 || data_valid_in2);

  assign uses_data_in1 = 1'b1;
  assign uses_data_in2 = need2;

  // Upper immediate placed in the top IMM_W bits of the word
  assign upper = XLEN'(data_in1[IMM_W-1:0]) << (XLEN - IMM_W);

  // Result selection; sums wrap naturally at XLEN bits
  always_comb begin
    result = '0;
    case (mode_e)
      OU_LUI:   result = upper;
      OU_AUIPC: result = upper + data_in2;
      OU_ADDI:  result = data_in2 + sext_iimm(data_in1);
      default:  result = '0;
    endcase
  end

  // Advance chain, walked from the output back to stage 0: a slot is free when it is
  // empty or its occupant moves on this cycle; the slot past the end is "free" on ack
  always_comb begin
    stg_move             = '0;
    stg_free             = '0;
    stg_free[PIPE_DEPTH] = data_out_ack;
    for (int i = PIPE_DEPTH - 1; i >= 0; i--) begin
      stg_move[i] = stg_vld[i] && stg_free[i+1];
      stg_free[i] = !stg_vld[i] || stg_move[i];
    end
  end

  // Operands are taken only when stage 0 can hold the result; nothing is acked in reset
  assign accept       = !rst && ready && stg_free[0];
  assign data_in_ack1 = accept;
  assign data_in_ack2 = accept && need2;

  // Stage 0 captures the fresh result; later stages take the previous stage's word
  for (genvar g = 0; g < PIPE_DEPTH; g++) begin : g_stage
    logic            stg_load;
    logic [XLEN-1:0] stg_din;

    if (g == 0) begin : g_head
      assign stg_load = accept;
      assign stg_din  = result;
    end else begin : g_body
      assign stg_load = stg_move[g-1];
      assign stg_din  = stg_dat[g-1];
    end

    ou_pipe_stage #(
      .W(XLEN)
    ) u_stage (
      .clk  (clk),
      .rst  (rst),
      .load (stg_load),
      .clr  (stg_move[g]),
      .d    (stg_din),
      .vld  (stg_vld[g]),
      .dat  (stg_dat[g])
    );
  end

  assign data_out       = stg_dat[PIPE_DEPTH-1];
  assign data_valid_out = stg_vld[PIPE_DEPTH-1];

  // Occupancy is the population count of stage valid bits
  always_comb begin
    occupancy = '0;
    for (int i = 0; i < PIPE_DEPTH; i++) begin
      occupancy = occupancy + 3'(stg_vld[i]);
    end
  end

`ifdef RCA_OU_STALL_CNT_EN
  logic [31:0] stall_cnt_q;

  // Count cycles where a result waits at the output; hold at all-ones instead of wrapping
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt_q <= '0;
    end else if (data_valid_out && !data_out_ack && (stall_cnt_q != '1)) begin
      stall_cnt_q <= stall_cnt_q + 32'd1;
    end
  end

  assign stall_count = stall_cnt_q;
`else
  assign stall_count = '0;
`endif

  // This unit never touches memory; the LSQ side is tied off
  assign addr        = '0;
  assign data        = '0;
  assign fn3         = '0;
  assign load        = 1'b0;
  assign store       = 1'b0;
  assign new_request = 1'b0;

  logic unused_ok;
  assign unused_ok = ^{lsq_full, load_data, load_complete, data_in1};

endmodule

// File: tb/tb_upper_imm_ou.sv
module tb_upper_imm_ou;
  import rca_config::*;

  logic            clk;
  logic            rst;
  logic [1:0]      mode;
  logic [XLEN-1:0] data_in1;
  logic [XLEN-1:0] data_in2;
  logic            data_valid_in1;
  logic            data_valid_in2;
  logic            data_in_ack1;
  logic            data_in_ack2;
  logic            uses_data_in1;
  logic            uses_data_in2;
  logic [XLEN-1:0] data_out;
  logic            data_valid_out;
  logic            data_out_ack;
  logic [2:0]      occupancy;
  logic [31:0]     stall_count;
  logic [XLEN-1:0] addr;
  logic [XLEN-1:0] data;
  logic [2:0]      fn3;
  logic            load;
  logic            store;
  logic            new_request;
  logic            lsq_full;
  logic [XLEN-1:0] load_data;
  logic            load_complete;

  int n_tests;
  int n_fail;

  upper_imm_ou #(
    .PIPE_DEPTH(2),
    .IMM_W(20)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .mode           (mode),
    .data_in1       (data_in1),
    .data_in2       (data_in2),
    .data_valid_in1 (data_valid_in1),
    .data_valid_in2 (data_valid_in2),
    .data_in_ack1   (data_in_ack1),
    .data_in_ack2   (data_in_ack2),
    .uses_data_in1  (uses_data_in1),
    .uses_data_in2  (uses_data_in2),
    .data_out       (data_out),
    .data_valid_out (data_valid_out),
    .data_out_ack   (data_out_ack),
    .occupancy      (occupancy),
    .stall_count    (stall_count),
    .addr           (addr),
    .data           (data),
    .fn3            (fn3),
    .load           (load),
    .store          (store),
    .new_request    (new_request),
    .lsq_full       (lsq_full),
    .load_data      (load_data),
    .load_complete  (load_complete)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Move to just after the next rising edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One isolated operation with downstream always ready; expects a 2-cycle latency
  task automatic one_op(input string tag, input logic [1:0] m, input logic [31:0] a,
                        input logic [31:0] b, input logic v2, input logic exp_use2,
                        input logic [31:0] exp);
    mode           = m;
    data_in1       = a;
    data_in2       = b;
    data_valid_in1 = 1'b1;
    data_valid_in2 = v2;
    data_out_ack   = 1'b1;
    #1;
    check({tag, " ack1"}, 32'(data_in_ack1), 32'd1);
    check({tag, " ack2"}, 32'(data_in_ack2), 32'(exp_use2));
    check({tag, " uses2"}, 32'(uses_data_in2), 32'(exp_use2));
    tick();
    data_valid_in1 = 1'b0;
    data_valid_in2 = 1'b0;
    #1;
    check({tag, " vld at +1"}, 32'(data_valid_out), 32'd0);
    tick();
    check({tag, " vld at +2"}, 32'(data_valid_out), 32'd1);
    check({tag, " result"}, data_out, exp);
    tick();
    check({tag, " vld after pop"}, 32'(data_valid_out), 32'd0);
  endtask

  int idx;
  int got;
  int last_cyc;

  initial begin
    n_tests        = 0;
    n_fail         = 0;
    rst            = 1'b1;
    mode           = 2'd1;
    data_in1       = 32'h0000_0012;
    data_in2       = 32'h8000_0100;
    data_valid_in1 = 1'b1;
    data_valid_in2 = 1'b1;
    data_out_ack   = 1'b0;
    lsq_full       = 1'b0;
    load_data      = '0;
    load_complete  = 1'b0;

    // Reset state, with operands offered to prove nothing is acked
    repeat (3) tick();
    check("rst vld", 32'(data_valid_out), 32'd0);
    check("rst data", data_out, 32'd0);
    check("rst occ", 32'(occupancy), 32'd0);
    check("rst stall", stall_count, 32'd0);
    check("rst ack1", 32'(data_in_ack1), 32'd0);
    check("rst ack2", 32'(data_in_ack2), 32'd0);
    check("uses1", 32'(uses_data_in1), 32'd1);
    check("lsq tie", {addr[15:0], data[15:0]} | 32'({fn3, load, store, new_request}), 32'd0);

    rst            = 1'b0;
    data_valid_in1 = 1'b0;
    data_valid_in2 = 1'b0;
    tick();

    // AUIPC waits for operand 2
    mode           = 2'd1;
    data_valid_in1 = 1'b1;
    data_valid_in2 = 1'b0;
    #1;
    check("auipc no op2 ack1", 32'(data_in_ack1), 32'd0);
    data_valid_in1 = 1'b0;
    tick();

    one_op("auipc",      2'd1, 32'h0001_2, 32'h8000_0100, 1'b1, 1'b1, 32'h8001_2100);
    one_op("lui",        2'd0, 32'hF_FFFF, 32'hDEAD_BEEF, 1'b0, 1'b0, 32'hFFFF_F000);
    one_op("addi",       2'd2, 32'h0000_0FFF, 32'h0000_0010, 1'b1, 1'b1, 32'h0000_000F);
    one_op("auipc wrap", 2'd1, 32'hF_FFFF, 32'h0000_1000, 1'b1, 1'b1, 32'h0000_0000);
    one_op("addi pos",   2'd2, 32'h0012_3123, 32'h0000_1000, 1'b1, 1'b1, 32'h0000_1123);
    one_op("rsvd",       2'd3, 32'h0001_2345, 32'h1111_1111, 1'b1, 1'b1, 32'h0000_0000);

    // Stream 8 LUI operands; output blocked for the first 4 cycles
    idx      = 0;
    got      = 0;
    last_cyc = -1;
    for (int cyc = 0; cyc < 40; cyc++) begin
      data_out_ack = (cyc >= 4);
      mode         = 2'd0;
      data_in1     = 32'(idx + 1);
      data_valid_in1 = (idx < 8);
      #1;
      if (cyc == 2) check("stream data c2", data_out, 32'h0000_1000);
      if (cyc == 3) begin
        check("stream occ full", 32'(occupancy), 32'd2);
        check("stream ack1 full", 32'(data_in_ack1), 32'd0);
        check("stream data held", data_out, 32'h0000_1000);
        check("stream vld held", 32'(data_valid_out), 32'd1);
      end
      if (data_in_ack1) idx++;
      if (data_valid_out && data_out_ack) begin
        check("stream order", data_out, 32'(got + 1) << 12);
        got++;
        if (got == 8) last_cyc = cyc;
      end
      if (got == 8) break;
      tick();
    end
    check("stream count", 32'(got), 32'd8);
    check("stream last cycle", 32'(last_cyc), 32'd11);
    tick();
    data_valid_in1 = 1'b0;
    #1;
    check("stream drained", 32'(occupancy), 32'd0);

    // Reset with two results in flight
    data_out_ack   = 1'b0;
    mode           = 2'd0;
    data_in1       = 32'h0000_0ABC;
    data_valid_in1 = 1'b1;
    tick();
    tick();
    data_valid_in1 = 1'b0;
    #1;
    check("inflight occ", 32'(occupancy), 32'd2);
    rst = 1'b1;
    tick();
    check("mid rst vld", 32'(data_valid_out), 32'd0);
    check("mid rst occ", 32'(occupancy), 32'd0);
    rst          = 1'b0;
    data_out_ack = 1'b1;
    got          = 0;
    for (int c = 0; c < 4; c++) begin
      tick();
      if (data_valid_out) got++;
    end
    check("no stale output", 32'(got), 32'd0);
    check("stall after rst", stall_count, 32'd0);

    // Hold a valid result unacked for 5 cycles
    data_out_ack   = 1'b0;
    mode           = 2'd0;
    data_in1       = 32'h0000_0001;
    data_valid_in1 = 1'b1;
    tick();
    data_valid_in1 = 1'b0;
    tick();
    check("stall hold vld", 32'(data_valid_out), 32'd1);
    repeat (5) tick();
`ifdef RCA_OU_STALL_CNT_EN
    check("stall count", stall_count, 32'd5);
`else
    check("stall count", stall_count, 32'd0);
`endif
    data_out_ack = 1'b1;
    tick();
    check("stall pop", 32'(data_valid_out), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
